// File: rtl/ahbl_i2s_sample_fifo_pkg.sv
// Package i2s_fifo_pkg: shared constants for the AHB-Lite I2S sample FIFO.
//   - Register word offsets (HADDR[4:2]) for the register map.
//   - STATUS register bit positions.
//   - AHB HTRANS encodings.
package i2s_fifo_pkg;

    // Register word offsets, compared against HADDR[4:2]
    localparam logic [2:0] RegDataL  = 3'h0;  // 0x00
    localparam logic [2:0] RegDataR  = 3'h1;  // 0x04
    localparam logic [2:0] RegStatus = 3'h2;  // 0x08
    localparam logic [2:0] RegCtrl   = 3'h3;  // 0x0C
    localparam logic [2:0] RegThresh = 3'h4;  // 0x10

    // STATUS bit positions; level occupies [AW:0]
    localparam int unsigned StatusOvfBit   = 31;
    localparam int unsigned StatusFullBit  = 17;
    localparam int unsigned StatusEmptyBit = 16;

    // CTRL bit positions
    localparam int unsigned CtrlEnableBit = 0;
    localparam int unsigned CtrlClearBit  = 1;

    typedef enum logic [1:0] {
        HtransIdle   = 2'b00,
        HtransBusy   = 2'b01,
        HtransNonseq = 2'b10,
        HtransSeq    = 2'b11
    } htrans_e;

endpackage

// File: rtl/ahbl_i2s_sample_fifo_sample_fifo.sv
// sample_fifo: circular buffer of Width-bit sample words.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i         request to store wdata_i (ignored when full unless a pop happens too)
//   pop_i          request to drop the head (ignored when empty)
//   flush_i        empty the buffer; wins over push/pop in the same cycle
//   wdata_i        word to store
//   rdata_o        head word, combinational (undefined content when empty)
//   level_o        current occupancy, 0..Depth
//   level_d_o      occupancy after the coming edge
//   full_o/empty_o occupancy flags
module sample_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Aw    = 4,
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic [Aw:0]      level_o,
    output logic [Aw:0]      level_d_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [Aw:0] LevelFull = (Aw + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Aw-1:0]    wr_ptr_q, wr_ptr_d;
    logic [Aw-1:0]    rd_ptr_q, rd_ptr_d;
    logic [Aw:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LevelFull);
    assign empty_o = (level_q == '0);

    // A pop on an empty buffer is a no-op; a push into a full buffer is only
    // accepted when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: content is only visible while level says it is valid.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o   = mem_q[rd_ptr_q];
    assign level_o   = level_q;
    assign level_d_o = level_d;

endmodule

// File: rtl/ahbl_i2s_sample_fifo.sv
// ahbl_i2s_sample_fifo: AHB-Lite slave buffering 64-bit {left, right} I2S sample words
// for the CPU, with a level-threshold interrupt.
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   smp_data, smp_valid  sample word and one-cycle strobe from the I2S receiver
//   HSEL..HWDATA         AHB-Lite slave inputs (HSIZE ignored, HADDR[4:2] decoded)
//   HRDATA               read data, combinational during the data phase
//   HREADYOUT, HRESP     constant 1 / 0: zero wait states, always OKAY
//   irq                  registered interrupt: level >= THRESH (THRESH = 0 disables)
module ahbl_i2s_sample_fifo
    import i2s_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [63:0] smp_data,
    input  logic        smp_valid,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        irq
);

    // Data-phase registers captured from the address phase
    logic [2:0]  dp_addr_q;
    logic        dp_write_q;
    logic        dp_valid_q;

    logic        enable_q, enable_d;
    logic [AW:0] thresh_q, thresh_d;
    logic        ovf_q, ovf_d;
    logic        irq_q, irq_d;

    logic        addr_phase;
    logic        dp_rd, dp_wr;
    logic        push_req, pop_req, flush, ovf_set;
    logic [63:0] head;
    logic [AW:0] level, level_d;
    logic        full, empty;
    logic        unused_inputs;

    assign addr_phase = HSEL & HREADY &
                        ((HTRANS == HtransNonseq) | (HTRANS == HtransSeq));
    assign dp_rd = dp_valid_q & ~dp_write_q;
    assign dp_wr = dp_valid_q & dp_write_q;

    assign push_req = smp_valid & enable_q;
    assign pop_req  = dp_rd & (dp_addr_q == RegDataR);
    assign flush    = dp_wr & (dp_addr_q == RegCtrl) & HWDATA[CtrlClearBit];
    // A full buffer with a simultaneous pop accepts the sample, so no overflow.
    assign ovf_set  = push_req & full & ~pop_req;

    sample_fifo #(
        .Depth (DEPTH),
        .Aw    (AW),
        .Width (64)
    ) u_sample_fifo (
        .clk_i     (HCLK),
        .rst_ni    (HRESETn),
        .push_i    (push_req),
        .pop_i     (pop_req),
        .flush_i   (flush),
        .wdata_i   (smp_data),
        .rdata_o   (head),
        .level_o   (level),
        .level_d_o (level_d),
        .full_o    (full),
        .empty_o   (empty)
    );

    always_comb begin
        enable_d = enable_q;
        thresh_d = thresh_q;
        ovf_d    = ovf_q;
        if (dp_wr && dp_addr_q == RegCtrl)   enable_d = HWDATA[CtrlEnableBit];
        if (dp_wr && dp_addr_q == RegThresh) thresh_d = HWDATA[AW:0];
        if (flush) begin
            ovf_d = 1'b0;
        end else begin
            if (dp_wr && dp_addr_q == RegStatus && HWDATA[StatusOvfBit]) ovf_d = 1'b0;
            // A new overflow wins over a W1C landing in the same cycle
            if (ovf_set) ovf_d = 1'b1;
        end
        // Use next-state threshold so irq tracks a THRESH write without a stale cycle
        irq_d = (thresh_d != '0) & (level_d >= thresh_d);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_addr_q  <= '0;
            dp_write_q <= 1'b0;
            dp_valid_q <= 1'b0;
            enable_q   <= 1'b0;
            thresh_q   <= '0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (HREADY) begin
                dp_valid_q <= addr_phase;
                dp_addr_q  <= HADDR[4:2];
                dp_write_q <= HWRITE;
            end
            enable_q <= enable_d;
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        HRDATA = '0;
        if (dp_rd) begin
            case (dp_addr_q)
                RegDataL:  HRDATA = empty ? '0 : head[63:32];
                RegDataR:  HRDATA = empty ? '0 : head[31:0];
                RegStatus: begin
                    HRDATA[StatusOvfBit]   = ovf_q;
                    HRDATA[StatusFullBit]  = full;
                    HRDATA[StatusEmptyBit] = empty;
                    HRDATA[AW:0]           = level;
                end
                RegCtrl:   HRDATA[CtrlEnableBit] = enable_q;
                RegThresh: HRDATA[AW:0] = thresh_q;
                default:   HRDATA = '0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign irq       = irq_q;

    assign unused_inputs = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA};

endmodule
